// File: rtl/noc_sched_pkg.sv
// Shared types and helpers for the NoC output-port scheduler.
// The optional statistics block is enabled with the SCHED_STATS_EN macro.
package noc_sched_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_FLIT_W  = 64;
  localparam int DEF_CREDITS = 4;
  localparam int DEF_CNT_W   = 16;
  localparam int PTR_W       = $clog2(DEF_NUM_REQ);

  // Round-robin successor of port p among n ports.
  function automatic int wrap_inc(input int p, input int n);
    return (p + 1 >= n) ? 0 : p + 1;
  endfunction

  // Extract flit idx from a packed bus of n flits of width w (w <= 1024).
  function automatic logic [1023:0] flit_field(input logic [8191:0] bus, input int idx,
                                               input int w);
    logic [1023:0] f;
    f = '0;
    for (int b = 0; b < w; b++) f[b] = bus[idx*w + b];
    return f;
  endfunction

endpackage

// File: rtl/output_port_scheduler_rr_pick.sv
// Combinational rotate-priority picker: first request at or after ptr (mod N).
// Returns a one-hot grant, its index and an any-request flag.
module rr_pick
  import noc_sched_pkg::*;
#(
  parameter int N  = DEF_NUM_REQ,
  parameter int PW = PTR_W
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] idx,
  output logic          any
);

  logic found;

  // NOTE: every output gets a default before the scan so no path can infer a latch.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    any   = |req;
    for (int k = 0; k < N; k++) begin
      int p;
      p = int'(ptr) + k;
      if (p >= N) p = p - N;
      if (!found && req[p]) begin
        found    = 1'b1;
        grant[p] = 1'b1;
        idx      = PW'(p);
      end
    end
  end

endmodule

// File: rtl/output_port_scheduler.sv
// Per-output-port scheduler: round-robin packet arbitration with credit flow control.
// Define SCHED_STATS_EN to add the per-port packet counters on pkt_cnt.
module output_port_scheduler
  import noc_sched_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int FLIT_W  = DEF_FLIT_W,
  parameter int CREDITS = DEF_CREDITS
`ifdef SCHED_STATS_EN
  ,
  parameter int CNT_W   = DEF_CNT_W
`endif
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*FLIT_W-1:0]   req_flit,
  input  logic [NUM_REQ-1:0]          req_tail,
  output logic [NUM_REQ-1:0]          req_pop,
  input  logic                        credit_ret,
  output logic                        out_valid,
  output logic [FLIT_W-1:0]           out_flit,
  output logic                        out_tail,
  output logic                        credit_err
`ifdef SCHED_STATS_EN
  ,
  output logic [NUM_REQ*CNT_W-1:0]    pkt_cnt
`endif
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(CREDITS + 1);

  state_t              state, state_nxt;
  logic [PW-1:0]       rr_ptr, rr_nxt;
  logic [PW-1:0]       owner, owner_nxt;
  logic [PW-1:0]       sel, pick_idx;
  logic [NUM_REQ-1:0]  pick_grant;
  logic                pick_any, eligible, send, sel_tail;
  logic [FLIT_W-1:0]   sel_flit;
  logic [CW-1:0]       credits;

  rr_pick #(.N(NUM_REQ), .PW(PW)) u_pick (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  always_comb begin
    state_nxt = state;
    rr_nxt    = rr_ptr;
    owner_nxt = owner;
    req_pop   = '0;
    sel       = pick_idx;
    eligible  = pick_any;
    if (state == LOCKED) begin
      sel      = owner;
      eligible = req_valid[owner];
    end
    // Registered credit count only: a credit returned this cycle cannot be spent yet.
    send     = eligible && (credits != '0) && !rst;
    sel_tail = req_tail[sel];
    sel_flit = req_flit[sel*FLIT_W +: FLIT_W];
    if (send) begin
      if (state == IDLE) req_pop = pick_grant;
      else               req_pop[owner] = 1'b1;
      if (sel_tail) begin
        rr_nxt    = PW'(wrap_inc(int'(sel), NUM_REQ));
        state_nxt = IDLE;
      end else begin
        owner_nxt = sel;
        state_nxt = LOCKED;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      owner      <= '0;
      credits    <= CW'(CREDITS);
      out_valid  <= 1'b0;
      out_flit   <= '0;
      out_tail   <= 1'b0;
      credit_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      rr_ptr    <= rr_nxt;
      owner     <= owner_nxt;
      out_valid <= send;
      if (send) begin
        out_flit <= sel_flit;
        out_tail <= sel_tail;
      end
      case ({send, credit_ret})
        2'b10:   credits <= credits - CW'(1);
        2'b01: begin
          if (credits == CW'(CREDITS)) credit_err <= 1'b1;
          else                         credits    <= credits + CW'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef SCHED_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_cnt <= '0;
    end else if (send && sel_tail) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (sel == PW'(i) && pkt_cnt[i*CNT_W +: CNT_W] != {CNT_W{1'b1}})
          pkt_cnt[i*CNT_W +: CNT_W] <= pkt_cnt[i*CNT_W +: CNT_W] + CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_output_port_scheduler.sv
// Self-checking bench for output_port_scheduler against a behavioural packet model.
// Build with SCHED_STATS_EN defined to also check pkt_cnt.
module tb_output_port_scheduler;

  localparam int N  = 4;
  localparam int FW = 64;
  localparam int C  = 4;
  localparam int CNTW = 16;

  typedef struct packed {
    logic [FW-1:0] f;
    logic          t;
  } ent_t;

  logic              clk, rst, credit_ret;
  logic [N-1:0]      req_valid, req_tail, req_pop;
  logic [N*FW-1:0]   req_flit;
  logic              out_valid, out_tail, credit_err;
  logic [FW-1:0]     out_flit;
`ifdef SCHED_STATS_EN
  logic [N*CNTW-1:0] pkt_cnt;
`endif

  output_port_scheduler #(.NUM_REQ(N), .FLIT_W(FW), .CREDITS(C)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_flit   (req_flit),
    .req_tail   (req_tail),
    .req_pop    (req_pop),
    .credit_ret (credit_ret),
    .out_valid  (out_valid),
    .out_flit   (out_flit),
    .out_tail   (out_tail),
    .credit_err (credit_err)
`ifdef SCHED_STATS_EN
    ,
    .pkt_cnt    (pkt_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  int seq    = 0;

  // Upstream FIFOs and the reference model state.
  ent_t          q[N][$];
  bit            gap[N];
  int            pop_log[$];
  int            m_credits, m_owner, m_rr;
  bit            m_locked, m_err, m_ov, m_ot;
  logic [FW-1:0] m_of;
  int            m_pkt[N];

  task automatic mreset();
    m_credits = C; m_locked = 0; m_owner = 0; m_rr = 0;
    m_err = 0; m_ov = 0; m_ot = 0; m_of = '0;
    for (int i = 0; i < N; i++) begin
      m_pkt[i] = 0; gap[i] = 0; q[i].delete();
    end
  endtask

  task automatic add_pkt(input int p, input int len);
    ent_t e;
    for (int k = 0; k < len; k++) begin
      e.f = {8'(p), 24'(seq), 32'($urandom)};
      e.t = (k == len - 1);
      seq++;
      q[p].push_back(e);
    end
  endtask

  function automatic bit same_order(input int e[$]);
    if (pop_log.size() != e.size()) return 0;
    foreach (e[k]) if (pop_log[k] != e[k]) return 0;
    return 1;
  endfunction

  // One clock cycle: drive inputs, compare DUT against the model, then advance the model.
  task automatic step(input bit r, input bit c);
    logic [N-1:0] v, e_pop;
    int w, p;
    ent_t hd;
    rst = r;
    credit_ret = c;
    for (int i = 0; i < N; i++) begin
      v[i] = (q[i].size() > 0) && !gap[i];
      req_valid[i] = v[i];
      req_flit[i*FW +: FW] = (q[i].size() > 0) ? q[i][0].f : '0;
      req_tail[i] = (q[i].size() > 0) ? q[i][0].t : 1'b0;
    end
    #3;
    w = -1;
    if (!r && m_credits > 0) begin
      if (m_locked) begin
        if (v[m_owner]) w = m_owner;
      end else begin
        for (int k = 0; k < N; k++) begin
          p = (m_rr + k) % N;
          if (w < 0 && v[p]) w = p;
        end
      end
    end
    e_pop = '0;
    if (w >= 0) e_pop[w] = 1'b1;
    total++;
    if (req_pop !== e_pop) $display("FAIL req_pop cyc=%0d got=%b exp=%b", cyc, req_pop, e_pop);
    else passed++;
    total++;
    if (out_valid !== m_ov) $display("FAIL out_valid cyc=%0d got=%b exp=%b", cyc, out_valid, m_ov);
    else passed++;
    if (m_ov) begin
      total++;
      if (out_flit !== m_of || out_tail !== m_ot)
        $display("FAIL out_flit cyc=%0d got=%h/%b exp=%h/%b", cyc, out_flit, out_tail, m_of, m_ot);
      else passed++;
    end
    total++;
    if (credit_err !== m_err) $display("FAIL credit_err cyc=%0d got=%b exp=%b", cyc, credit_err, m_err);
    else passed++;
`ifdef SCHED_STATS_EN
    for (int i = 0; i < N; i++) begin
      total++;
      if (pkt_cnt[i*CNTW +: CNTW] !== CNTW'(m_pkt[i]))
        $display("FAIL pkt_cnt%0d cyc=%0d got=%0d exp=%0d", i, cyc, pkt_cnt[i*CNTW +: CNTW], m_pkt[i]);
      else passed++;
    end
`endif
    for (int k = 0; k < N; k++) if (req_pop[k]) begin pop_log.push_back(k); break; end
    @(posedge clk);
    cyc++;
    if (r) begin
      mreset();
    end else begin
      m_ov = (w >= 0);
      if (w >= 0) begin
        hd = q[w].pop_front();
        m_of = hd.f;
        m_ot = hd.t;
        if (hd.t) begin
          m_rr = (w + 1) % N;
          m_locked = 0;
          if (m_pkt[w] < (1 << CNTW) - 1) m_pkt[w]++;
        end else begin
          m_locked = 1;
          m_owner = w;
        end
      end
      if (w >= 0 && !c) m_credits--;
      else if (w < 0 && c) begin
        if (m_credits == C) m_err = 1;
        else m_credits++;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    add_pkt(0, 1);
    add_pkt(2, 2);
    step(1, 1);
    total++;
    if (out_valid !== 1'b0 || out_flit !== '0 || out_tail !== 1'b0 || credit_err !== 1'b0)
      $display("FAIL reset_outputs got=%b/%h/%b/%b exp=0/0/0/0", out_valid, out_flit, out_tail, credit_err);
    else passed++;
  endtask

  task automatic test_round_robin();
    int e[$];
    e = '{0, 1, 2, 3, 0, 1, 2, 3};
    pop_log.delete();
    for (int r = 0; r < 2; r++) for (int i = 0; i < N; i++) add_pkt(i, 1);
    repeat (8) step(0, 1);
    repeat (2) step(0, 0);
    total++;
    if (!same_order(e)) $display("FAIL order_rr got=%p exp=%p", pop_log, e);
    else passed++;
  endtask

  task automatic test_packet_lock();
    int e[$];
    e = '{0, 1, 1, 1, 2};
    pop_log.delete();
    add_pkt(1, 3);
    add_pkt(0, 1);
    add_pkt(2, 1);
    repeat (5) step(0, 1);
    repeat (2) step(0, 0);
    total++;
    if (!same_order(e)) $display("FAIL order_lock got=%p exp=%p", pop_log, e);
    else passed++;
  endtask

  task automatic test_credit_stall();
    int n0, n1;
    step(1, 0);
    pop_log.delete();
    for (int r = 0; r < 3; r++) for (int i = 0; i < N; i++) add_pkt(i, 1);
    repeat (8) step(0, 0);
    total++;
    if (pop_log.size() != C) $display("FAIL stall_sends got=%0d exp=%0d", pop_log.size(), C);
    else passed++;
    n0 = pop_log.size();
    step(0, 1);
    total++;
    if (pop_log.size() != n0) $display("FAIL pulse_cycle got=%0d exp=%0d", pop_log.size() - n0, 0);
    else passed++;
    step(0, 0);
    n1 = pop_log.size();
    repeat (3) step(0, 0);
    total++;
    if (n1 != n0 + 1 || pop_log.size() != n1)
      $display("FAIL after_pulse got=%0d/%0d exp=1/0", n1 - n0, pop_log.size() - n1);
    else passed++;
  endtask

  task automatic test_gap();
    int e[$];
    e = '{3, 3, 3, 0};
    step(1, 0);
    pop_log.delete();
    add_pkt(3, 3);
    step(0, 0);
    add_pkt(0, 1);
    step(0, 0);
    gap[3] = 1;
    repeat (2) step(0, 0);
    total++;
    if (pop_log.size() != 2) $display("FAIL gap_pops got=%0d exp=2", pop_log.size());
    else passed++;
    gap[3] = 0;
    repeat (4) step(0, 0);
    total++;
    if (!same_order(e)) $display("FAIL order_gap got=%p exp=%p", pop_log, e);
    else passed++;
  endtask

  task automatic test_credit_err();
    step(1, 0);
    step(0, 1);
    repeat (4) step(0, 0);
    total++;
    if (credit_err !== 1'b1) $display("FAIL err_sticky got=%b exp=1", credit_err);
    else passed++;
    pop_log.delete();
    for (int r = 0; r < 2; r++) for (int i = 0; i < N; i++) add_pkt(i, 1);
    repeat (8) step(0, 0);
    total++;
    if (pop_log.size() != C) $display("FAIL err_credits got=%0d exp=%0d", pop_log.size(), C);
    else passed++;
  endtask

  task automatic test_reset_mid();
    int e[$];
    e = '{0, 1, 2, 3};
    step(1, 0);
    add_pkt(1, 1);
    step(0, 0);
    add_pkt(2, 3);
    repeat (2) step(0, 0);
    total++;
    if (out_valid !== 1'b1) $display("FAIL pre_reset_valid got=%b exp=1", out_valid);
    else passed++;
    step(1, 0);
    total++;
    if (out_valid !== 1'b0) $display("FAIL post_reset_valid got=%b exp=0", out_valid);
    else passed++;
    pop_log.delete();
    add_pkt(1, 1); add_pkt(3, 1); add_pkt(0, 1);
    add_pkt(2, 1); add_pkt(1, 1); add_pkt(3, 1);
    repeat (8) step(0, 0);
    total++;
    if (!same_order(e)) $display("FAIL order_after_reset got=%p exp=%p", pop_log, e);
    else passed++;
  endtask

  task automatic test_random();
    step(1, 0);
    for (int t = 0; t < 400; t++) begin
      if ($urandom_range(0, 2) == 0) begin
        int p;
        p = $urandom_range(0, N - 1);
        if (q[p].size() < 6) add_pkt(p, $urandom_range(1, 3));
      end
      for (int i = 0; i < N; i++) gap[i] = ($urandom_range(0, 5) == 0);
      step(0, ($urandom_range(0, 9) < 4));
    end
  endtask

  initial begin
    rst = 1'b1;
    credit_ret = 1'b0;
    req_valid = '0;
    req_flit = '0;
    req_tail = '0;
    mreset();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_round_robin();
    test_packet_lock();
    test_credit_stall();
    test_gap();
    test_credit_err();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
